mag_envelope_detector: RTL and testbench
========================================

# mag_envelope_detector

Downstream consumer of the I/Q magnitude stage. It takes each unsigned magnitude sample with its valid strobe and keeps a moving average over a power-of-two window. A hysteresis comparator on that average raises and drops a signal-detect flag. Its outputs feed the detection/AGC control logic.

## Interface
Parameters:
- DATA_W, 16, magnitude sample width (unsigned Q0.15 magnitude from the sqrt stage)
- LOG2_LEN, 4, log2 of the averaging window length N (N = 16 by default); legal range 1..8

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- mag_in  in  DATA_W  magnitude sample
- mag_valid  in  1  mag_in is valid this cycle (driven by the magnitude stage's done)
- clr  in  1  synchronous flush of window, sum, detect
- thr_on  in  DATA_W  average at or above which detect sets
- thr_off  in  DATA_W  average below which detect clears
- avg_out  out  DATA_W  current window average
- avg_valid  out  1  one-cycle strobe: avg_out updated with a full-window average
- detect  out  1  hysteresis detect flag
- peak_out  out  DATA_W  peak magnitude since last clear (see Configuration)
- peak_clr  in  1  clears the peak register (see Configuration)

## Operation
- States: FILL (after reset or clr) and RUN.
- Storage:
  - Window is a circular buffer of N entries, DATA_W wide, with a wrap-around write pointer wr_ptr (LOG2_LEN bits).
  - Running sum is DATA_W+LOG2_LEN bits wide, so it can never overflow.
  - fill_cnt counts 0..N.
- Accepted sample: mag_valid=1 and clr=0 and rst=0. On each accepted sample:
  - oldest = (state==FILL) ? 0 : buf[wr_ptr]. Buffer contents are never reset; FILL masks stale entries.
  - sum <= sum + mag_in - oldest; buf[wr_ptr] <= mag_in; wr_ptr <= wr_ptr+1 (wraps N-1 -> 0).
  - In FILL: fill_cnt++. When fill_cnt reaches N, go to RUN. The sample that completes the window counts as a RUN update.
- Average: avg_out = sum >> LOG2_LEN, truncated, computed from the registered sum.
- Detect (evaluated only on updates that also strobe avg_valid, using the new average):
  - When detect=0: set if avg_new >= thr_on.
  - When detect=1: clear if avg_new < thr_off.
  - Only one of set/clear is evaluated per update, so detect changes at most once per update.
  - If thr_off > thr_on, detect may toggle on successive samples; this is permitted and not guarded.
- clr: sum, wr_ptr, fill_cnt and detect go to 0, state goes to FILL, avg_valid is 0 the next cycle.
  - clr with mag_valid in the same cycle: the sample is dropped.
  - clr does not affect peak.
- Reset mid-window: identical to clr, and additionally clears the peak register.
- Bursts: back-to-back mag_valid is supported at full rate, one sample per clock, with no backpressure.

## Timing
- Reset values: avg_out=0, avg_valid=0, detect=0, peak_out=0, state=FILL.
- Latency: accepted sample in cycle T -> updated avg_out, detect and avg_valid visible in cycle T+1.
- avg_valid:
  - Pulses exactly one cycle per accepted sample in RUN, including the N-th sample after reset or clr.
  - Never asserted during FILL.
- First valid average after reset: the N-th accepted sample. No avg_valid for samples 1..N-1.
- avg_out holds its value between strobes. During FILL it tracks the partial sum >> LOG2_LEN but is not strobed.
- Thresholds are sampled in the same cycle as the accepted sample.

## Configuration
- Macro: MAG_ENV_PEAK_HOLD_EN.
- Defined:
  - The peak register updates on each accepted sample: peak <= max(peak, mag_in).
  - peak_clr=1 without a sample: peak <= 0.
  - peak_clr=1 with an accepted sample: peak <= mag_in.
  - peak_out is registered, with a 1-cycle latency.
- Undefined: peak_out is tied to 0, peak_clr is ignored, and no peak register is built.

## Structure
- Shared package mag_pkg holds:
  - DATA_W default
  - LOG2_LEN default
  - the state enum (FILL, RUN)
  - the derived SUM_W = DATA_W+LOG2_LEN constant
- Sub-module mag_delay_line:
  - N x DATA_W circular buffer with asynchronous read of buf[wr_ptr] and synchronous write.
  - Owns wr_ptr and outputs the oldest sample.
- Top level holds the FILL/RUN control, sum, comparator and peak logic.

## Test plan
- Fill: reset, then 16 samples of 0x4000 -> no avg_valid for samples 1–15; avg_valid one cycle after the 16th with avg_out=0x4000.
- Sliding window and wrap: after the fill, 16 samples of 0x2000 -> avg_out steps down by 0x0200 per sample and reaches 0x2000. wr_ptr wraps without glitches, no overflow in sum.
- Hysteresis with thr_on=0x3000, thr_off=0x1000:
  - Ramping average 0x2000 -> 0x3000 sets detect.
  - Falling back to 0x1800 keeps detect=1.
  - 0x0FF0 clears it.
- clr mid-RUN with mag_valid=1 in the same cycle:
  - The sample is dropped, detect=0, and the next avg_valid comes only after 16 new samples.
  - Repeat with rst: all outputs 0 one cycle later.
- Full-scale: 16 samples of 0xFFFF -> avg_out=0xFFFF, sum=0xFFFF0, with no wrap.
- Peak with MAG_ENV_PEAK_HOLD_EN:
  - Sequence 0x1000, 0x7000, 0x2000 -> peak_out=0x7000.
  - peak_clr together with 0x0300 -> peak_out=0x0300.
  - Without the macro, peak_out stays 0 throughout.

Source files
------------

// File: rtl/mag_pkg.sv
// rtl/mag_pkg.sv - shared defaults, window state enum and sum width for the envelope detector
package mag_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int LOG2_LEN_DEF = 4;
  localparam int SUM_W_DEF    = DATA_W_DEF + LOG2_LEN_DEF;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } mag_state_t;

  function automatic int sum_width(input int data_w, input int log2_len);
    return data_w + log2_len;
  endfunction

endpackage

// File: rtl/mag_delay_line.sv
// rtl/mag_delay_line.sv - N-entry circular sample buffer; presents the entry about to be overwritten
module mag_delay_line
  import mag_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_LEN = LOG2_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest
);

  localparam int N = 1 << LOG2_LEN;

  logic [DATA_W-1:0]   mem [N];
  logic [LOG2_LEN-1:0] wr_ptr;

  // Contents are never cleared; the top masks stale entries while filling.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

  assign oldest = mem[wr_ptr];

endmodule

// File: rtl/mag_envelope_detector.sv
// rtl/mag_envelope_detector.sv - moving-average envelope with hysteresis detect; optional peak hold via MAG_ENV_PEAK_HOLD_EN
module mag_envelope_detector
  import mag_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_LEN = LOG2_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mag_in,
  input  logic              mag_valid,
  input  logic              clr,
  input  logic [DATA_W-1:0] thr_on,
  input  logic [DATA_W-1:0] thr_off,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              detect,
  output logic [DATA_W-1:0] peak_out,
  input  logic              peak_clr
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_LEN);
  localparam int N     = 1 << LOG2_LEN;
  localparam logic [LOG2_LEN:0] FILL_LAST = (LOG2_LEN + 1)'(N - 1);

  mag_state_t          state_q, state_d;
  logic [LOG2_LEN:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_q, sum_d, sum_new;
  logic                valid_q, valid_d;
  logic                detect_q, detect_d;
  logic                strobe;
  logic [DATA_W-1:0]   oldest, oldest_m, avg_new;
  logic                accepted;

  assign accepted = mag_valid && !clr && !rst;

  mag_delay_line #(
    .DATA_W   (DATA_W),
    .LOG2_LEN (LOG2_LEN)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (accepted),
    .wr_data (mag_in),
    .oldest  (oldest)
  );

  assign oldest_m = (state_q == FILL) ? '0 : oldest;
  assign sum_new  = sum_q + SUM_W'(mag_in) - SUM_W'(oldest_m);
  assign avg_new  = sum_new[SUM_W-1:LOG2_LEN];

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    sum_d    = sum_q;
    valid_d  = 1'b0;
    detect_d = detect_q;
    strobe   = 1'b0;
    if (clr) begin
      state_d  = FILL;
      fill_d   = '0;
      sum_d    = '0;
      detect_d = 1'b0;
    end else if (mag_valid) begin
      sum_d = sum_new;
      if (state_q == FILL) begin
        fill_d = fill_q + 1'b1;
        // The sample completing the window is already a full-window update.
        if (fill_q == FILL_LAST) begin
          state_d = RUN;
          strobe  = 1'b1;
        end
      end else begin
        strobe = 1'b1;
      end
      if (strobe) begin
        valid_d = 1'b1;
        if (!detect_q) detect_d = (avg_new >= thr_on);
        else           detect_d = !(avg_new < thr_off);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      fill_q   <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      sum_q    <= sum_d;
      valid_q  <= valid_d;
      detect_q <= detect_d;
    end
  end

  assign avg_out   = sum_q[SUM_W-1:LOG2_LEN];
  assign avg_valid = valid_q;
  assign detect    = detect_q;

`ifdef MAG_ENV_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else if (peak_clr) peak_q <= accepted ? mag_in : '0;
    else if (accepted && (mag_in > peak_q)) peak_q <= mag_in;
  end

  assign peak_out = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_out        = '0;
`endif

endmodule

// File: tb/tb_mag_envelope_detector.sv
// tb/tb_mag_envelope_detector.sv - randomized and directed bench with a queue-based window model
module tb_mag_envelope_detector;

  localparam int DW = 16;
  localparam int LG = 4;
  localparam int N  = 1 << LG;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mag_in = '0;
  logic          mag_valid = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] thr_on = 16'hFFFF;
  logic [DW-1:0] thr_off = 16'h0000;
  logic          peak_clr = 1'b0;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          detect;
  logic [DW-1:0] peak_out;

  mag_envelope_detector #(.DATA_W(DW), .LOG2_LEN(LG)) dut (
    .clk       (clk),
    .rst       (rst),
    .mag_in    (mag_in),
    .mag_valid (mag_valid),
    .clr       (clr),
    .thr_on    (thr_on),
    .thr_off   (thr_off),
    .avg_out   (avg_out),
    .avg_valid (avg_valid),
    .detect    (detect),
    .peak_out  (peak_out),
    .peak_clr  (peak_clr)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int            win[$];
  logic [DW-1:0] exp_avg = '0;
  logic          exp_valid = 1'b0;
  logic          exp_det = 1'b0;
  logic [DW-1:0] exp_peak = '0;

  // Reference: the window is literally the last N accepted samples, averaged by division.
  task automatic model_step(input bit r, input bit v, input bit c, input bit pc, input logic [DW-1:0] d);
    bit acc;
    int s;
    acc = v && !c && !r;
    if (r) begin
      win.delete();
      exp_det  = 1'b0;
      exp_peak = '0;
    end else if (c) begin
      win.delete();
      exp_det = 1'b0;
    end
    if (acc) begin
      win.push_back(int'(d));
      if (win.size() > N) void'(win.pop_front());
    end
    exp_valid = acc && (win.size() == N);
    s = 0;
    foreach (win[i]) s += win[i];
    exp_avg = DW'(s / N);
    if (exp_valid) begin
      if (!exp_det) exp_det = (exp_avg >= thr_on);
      else if (exp_avg < thr_off) exp_det = 1'b0;
    end
`ifdef MAG_ENV_PEAK_HOLD_EN
    if (!r) begin
      if (pc) exp_peak = acc ? d : '0;
      else if (acc && d > exp_peak) exp_peak = d;
    end
`endif
  endtask

  task automatic step(input bit r, input bit v, input bit c, input bit pc, input logic [DW-1:0] d);
    rst = r; mag_valid = v; clr = c; peak_clr = pc; mag_in = d;
    @(posedge clk);
    model_step(r, v, c, pc, d);
    #1;
    rst = 1'b0; mag_valid = 1'b0; clr = 1'b0; peak_clr = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 16'h0);
    step(1, 1, 0, 0, 16'h1234);
    total++;
    if ({avg_out, avg_valid, detect, peak_out} !== {16'h0, 1'b0, 1'b0, 16'h0}) begin
      $display("FAIL reset: avg=%h v=%b det=%b peak=%h, want all zero", avg_out, avg_valid, detect, peak_out);
    end else passed++;
  endtask

  task automatic test_fill();
    int early_valid = 0;
    thr_on = 16'hFFFF; thr_off = 16'h0000;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 0, 16'h4000);
      if (i < N - 1 && avg_valid) early_valid++;
    end
    total++;
    if (early_valid !== 0) $display("FAIL fill_no_early_valid: got %0d strobes, want 0", early_valid);
    else passed++;
    total++;
    if ({avg_valid, avg_out} !== {1'b1, 16'h4000}) $display("FAIL fill_done: v=%b avg=%h, want 1 4000", avg_valid, avg_out);
    else passed++;
  endtask

  task automatic test_slide();
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 0, 16'h2000);
      total++;
      if ({avg_valid, avg_out} !== {1'b1, 16'(16'h4000 - 16'h0200 * (i + 1))})
        $display("FAIL slide[%0d]: v=%b avg=%h, want 1 %h", i, avg_valid, avg_out, 16'(16'h4000 - 16'h0200 * (i + 1)));
      else passed++;
    end
  endtask

  task automatic test_hysteresis();
    logic seen_set = 1'b0, kept = 1'b1, seen_clr = 1'b0;
    thr_on = 16'h3000; thr_off = 16'h1000;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, 16'h4000);
      if (i == 6 && detect) kept = 1'b0;
    end
    seen_set = detect;
    total++;
    if ({kept, seen_set, avg_out} !== {1'b1, 1'b1, 16'h3000}) $display("FAIL hyst_set: early=%b det=%b avg=%h, want 1 1 3000", !kept, seen_set, avg_out);
    else passed++;
    kept = 1'b1;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 0, 16'h1800);
      if (!detect) kept = 1'b0;
    end
    total++;
    if ({kept, avg_out} !== {1'b1, 16'h1800}) $display("FAIL hyst_hold: kept=%b avg=%h, want 1 1800", kept, avg_out);
    else passed++;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 0, 16'h0FF0);
      total++;
      if ({avg_out, avg_valid, detect} !== {exp_avg, exp_valid, exp_det})
        $display("FAIL hyst_fall[%0d]: avg=%h v=%b det=%b, want %h %b %b", i, avg_out, avg_valid, detect, exp_avg, exp_valid, exp_det);
      else passed++;
    end
    seen_clr = !detect;
    total++;
    if ({seen_clr, avg_out} !== {1'b1, 16'h0FF0}) $display("FAIL hyst_clear: det=%b avg=%h, want 0 0ff0", detect, avg_out);
    else passed++;
  endtask

  task automatic test_clr_mid_run();
    int early_valid = 0;
    thr_on = 16'h0800; thr_off = 16'h0100;
    step(0, 1, 0, 0, 16'h0FF0);
    step(0, 1, 1, 0, 16'h7777);
    total++;
    if ({avg_out, avg_valid, detect} !== {16'h0, 1'b0, 1'b0}) $display("FAIL clr_drop: avg=%h v=%b det=%b, want 0 0 0", avg_out, avg_valid, detect);
    else passed++;
    for (int i = 0; i < N; i++) begin
      step(0, 1, 0, 0, 16'h1000);
      if (i < N - 1 && avg_valid) early_valid++;
    end
    total++;
    if ({early_valid == 0, avg_valid, avg_out, detect} !== {1'b1, 1'b1, 16'h1000, 1'b1})
      $display("FAIL clr_refill: early=%0d v=%b avg=%h det=%b, want 0 1 1000 1", early_valid, avg_valid, avg_out, detect);
    else passed++;
    step(1, 1, 0, 0, 16'h5555);
    total++;
    if ({avg_out, avg_valid, detect, peak_out} !== {16'h0, 1'b0, 1'b0, 16'h0})
      $display("FAIL rst_mid: avg=%h v=%b det=%b peak=%h, want all zero", avg_out, avg_valid, detect, peak_out);
    else passed++;
  endtask

  task automatic test_full_scale();
    thr_on = 16'hFFFF; thr_off = 16'h0000;
    for (int i = 0; i < N; i++) step(0, 1, 0, 0, 16'hFFFF);
    total++;
    if ({avg_valid, avg_out, detect} !== {1'b1, 16'hFFFF, 1'b1}) $display("FAIL full_scale: v=%b avg=%h det=%b, want 1 ffff 1", avg_valid, avg_out, detect);
    else passed++;
    step(0, 1, 0, 0, 16'hFFFF);
    total++;
    if (avg_out !== 16'hFFFF) $display("FAIL full_scale_hold: avg=%h, want ffff", avg_out);
    else passed++;
  endtask

  task automatic test_peak();
    logic [DW-1:0] want1, want2;
`ifdef MAG_ENV_PEAK_HOLD_EN
    want1 = 16'h7000; want2 = 16'h0300;
`else
    want1 = 16'h0000; want2 = 16'h0000;
`endif
    step(0, 0, 0, 1, 16'h0);
    step(0, 1, 0, 0, 16'h1000);
    step(0, 1, 0, 0, 16'h7000);
    step(0, 1, 0, 0, 16'h2000);
    total++;
    if (peak_out !== want1) $display("FAIL peak_max: peak=%h, want %h", peak_out, want1);
    else passed++;
    step(0, 1, 1, 0, 16'h0100);
    total++;
    if (peak_out !== want1) $display("FAIL peak_clr_keeps: peak=%h, want %h", peak_out, want1);
    else passed++;
    step(0, 1, 0, 1, 16'h0300);
    total++;
    if (peak_out !== want2) $display("FAIL peak_clr_sample: peak=%h, want %h", peak_out, want2);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        thr_on  = DW'($urandom_range(16'h8000));
        thr_off = DW'($urandom_range(16'h8000));
      end
      step($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(59) == 0,
           $urandom_range(29) == 0, DW'($urandom));
      total++;
      if ({avg_out, avg_valid, detect, peak_out} !== {exp_avg, exp_valid, exp_det, exp_peak})
        $display("FAIL random[%0d]: avg=%h v=%b det=%b peak=%h, want %h %b %b %h",
                 i, avg_out, avg_valid, detect, peak_out, exp_avg, exp_valid, exp_det, exp_peak);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_slide();
    test_hysteresis();
    test_clr_mid_run();
    test_full_scale();
    test_peak();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
